// File: rtl/ps2_pkg.sv
// PS/2 scan decoder shared types and constants.
// Frame FSM state encoding and the event record carried by the FIFO.
package ps2_pkg;

  localparam logic [7:0] EXTENDED_SCAN_CODE = 8'hE0;
  localparam logic [7:0] KEY_UP_SCAN_CODE   = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // "break" is a keyword, so the release flag is brk.
  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO: power-of-two ring, head shown combinationally.
// Ports: push/push_data in, pop in, head/not_empty/count/drop out.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type evt_t = ps2_evt_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  evt_t                   push_data,
  input  logic                   pop,
  output evt_t                   head,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign not_empty = ~empty;
  assign pop_ok    = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok   = push & (~full | pop_ok);
  assign drop      = push & ~push_ok;
  // Gate so the head reads zero while empty, storage needs no reset.
  assign head      = empty ? evt_t'('0) : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: sync, deglitch, frame FSM, prefix decode, FIFO.
// clk, async active-high data_ready_clk_reset; kbd_* raw; evt_* stream; sticky errs.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        data_ready_clk_reset,
  input  logic                        kbd_clk,
  input  logic                        kbd_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_extended,
  output logic                        evt_break,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        err_clear
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic rst;
  assign rst = data_ready_clk_reset;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          flt;
  logic          flt_d;
  logic          clk_fall;
  logic          bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], kbd_clk};
      dat_sync <= {dat_sync[0], kbd_data};
    end
  end

  // Level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt     <= 1'b1;
      flt_d   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      flt_d <= flt;
      if (clk_sync[1] != flt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          flt     <= clk_sync[1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign clk_fall = flt_d & ~flt;
  assign bit_in   = dat_sync[1];

  frame_state_t  state;
  frame_state_t  state_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          par_bad;
  logic          par_bad_n;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_n;
  logic          byte_n;
  logic          perr_ev;
  logic          ferr_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_bad <= par_bad_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_bad_n = par_bad;
    to_cnt_n  = '0;
    byte_n    = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clk_fall) begin
          if (!bit_in) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
            par_bad_n = 1'b0;
          end else begin
            ferr_ev = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          shift_n = {bit_in, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = ST_PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          if (!(^{shift, bit_in})) begin
            par_bad_n = 1'b1;
            perr_ev   = 1'b1;
          end
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          state_n = ST_IDLE;
          if (!bit_in) begin
            ferr_ev = 1'b1;
          end else if (!par_bad) begin
            byte_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Watchdog on a stalled partial frame.
    if (state != ST_IDLE && !clk_fall) begin
      if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state_n   = ST_IDLE;
        bit_cnt_n = '0;
        ferr_ev   = 1'b1;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end
  end

  logic       byte_vld;
  logic [7:0] byte_q;
  logic       pend_ext;
  logic       pend_brk;
  logic       is_ext;
  logic       is_brk;
  logic       push;
  ps2_evt_t   push_evt;
  ps2_evt_t   head;
  logic       ovf_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_vld <= byte_n;
      if (byte_n) begin
        byte_q <= shift;
      end
    end
  end

  assign is_ext = (byte_q == EXTENDED_SCAN_CODE);
  assign is_brk = (byte_q == KEY_UP_SCAN_CODE);
  assign push   = byte_vld & ~is_ext & ~is_brk;

  assign push_evt.extended = pend_ext;
  assign push_evt.brk      = pend_brk;
  assign push_evt.code     = byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (ferr_ev) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (byte_vld) begin
      unique case (1'b1)
        is_ext: pend_ext <= 1'b1;
        is_brk: pend_brk <= 1'b1;
        default: begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
        end
      endcase
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .evt_t (ps2_evt_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .head      (head),
    .not_empty (evt_valid),
    .count     (evt_count),
    .drop      (ovf_ev)
  );

  assign evt_code     = head.code;
  assign evt_extended = head.extended;
  assign evt_break    = head.brk;

  // A new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~err_clear) | perr_ev;
      frame_err  <= (frame_err  & ~err_clear) | ferr_ev;
      overflow   <= (overflow   & ~err_clear) | ovf_ev;
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder.
// Drives PS/2 frames bit by bit and checks events and error flags.
module tb_ps2_scan_decoder;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TOUT  = 400;

  logic       clk;
  logic       rst;
  logic       kbd_clk;
  logic       kbd_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_extended;
  logic       evt_break;
  logic [2:0] evt_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       err_clear;

  int checks;
  int failures;
  int n;

  ps2_scan_decoder #(
    .FIFO_DEPTH  (DEPTH),
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk                  (clk),
    .data_ready_clk_reset (rst),
    .kbd_clk              (kbd_clk),
    .kbd_data             (kbd_data),
    .evt_valid            (evt_valid),
    .evt_ready            (evt_ready),
    .evt_code             (evt_code),
    .evt_extended         (evt_extended),
    .evt_break            (evt_break),
    .evt_count            (evt_count),
    .parity_err           (parity_err),
    .frame_err            (frame_err),
    .overflow             (overflow),
    .err_clear            (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    kbd_data = b;
    cyc(10);
    kbd_clk = 1'b0;
    cyc(20);
    kbd_clk = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(stop);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic pop1;
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    cyc(1);
  endtask

  task automatic clr_err;
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [7:0] a;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    kbd_clk   = 1'b1;
    kbd_data  = 1'b1;
    evt_ready = 1'b0;
    err_clear = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(2);

    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_head", {evt_extended, evt_break, evt_code}, 0);
    chk("rst_errs", {parity_err, frame_err, overflow}, 0);
    chk("rst_state", dut.state, ST_IDLE);
    chk("rst_filter", dut.flt, 1);

    a = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(a[i]);
    send_bit(~(^a));
    kbd_data = 1'b1;
    cyc(10);
    kbd_clk = 1'b0;
    n = 0;
    while (dut.clk_fall !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("stop_edge_seen", n < 40, 1);
    n = 0;
    while (evt_valid !== 1'b1 && n < 10) begin
      cyc(1);
      n++;
    end
    chk("stop_to_valid_le3", n <= 3, 1);
    cyc(20);
    kbd_clk = 1'b1;
    cyc(10);
    chk("make_count", evt_count, 1);
    chk("make_evt", {evt_extended, evt_break, evt_code}, 10'h01C);
    pop1();
    chk("make_popped", evt_count, 0);

    send_byte(8'hF0);
    chk("f0_no_evt", evt_count, 0);
    send_byte(8'h1C);
    chk("brk_count", evt_count, 1);
    chk("brk_evt", {evt_extended, evt_break, evt_code}, 10'h11C);
    pop1();

    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("extbrk_count", evt_count, 1);
    chk("extbrk_evt", {evt_extended, evt_break, evt_code}, 10'h375);
    pop1();

    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_no_evt", evt_count, 0);
    chk("par_err", {parity_err, frame_err}, 2'b10);
    clr_err();
    chk("par_clear", parity_err, 0);

    send_frame(8'h1C, 1'b0, 1'b0);
    chk("stop0_no_evt", evt_count, 0);
    chk("stop0_ferr", frame_err, 1);
    clr_err();

    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'h25);
    chk("full_no_ovf", overflow, 0);
    send_byte(8'h2E);
    chk("ovf_count", evt_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_code, 8'h16);
    pop1();
    chk("drain_1", evt_code, 8'h1E);
    pop1();
    chk("drain_2", evt_code, 8'h26);
    pop1();
    chk("drain_3", evt_code, 8'h25);
    pop1();
    chk("drain_empty", {evt_valid, evt_count}, 0);
    pop1();
    chk("pop_empty", evt_count, 0);
    clr_err();
    chk("ovf_clear", overflow, 0);

    send_byte(8'hE0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("partial_busy", dut.state != ST_IDLE, 1);
    cyc(TOUT + 20);
    chk("to_ferr", frame_err, 1);
    chk("to_idle", dut.state, ST_IDLE);
    chk("to_no_evt", evt_count, 0);
    clr_err();
    send_byte(8'h29);
    chk("to_next_evt", {evt_extended, evt_break, evt_code}, 10'h029);
    pop1();

    for (int g = 1; g < FLEN; g++) begin
      kbd_clk = 1'b0;
      cyc(g);
      kbd_clk = 1'b1;
      cyc(8);
    end
    chk("glitch_no_evt", evt_count, 0);
    chk("glitch_errs", {parity_err, frame_err, overflow}, 0);
    chk("glitch_idle", dut.state, ST_IDLE);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("midrst_state", dut.state, ST_IDLE);
    send_byte(8'h1C);
    chk("midrst_evt", {evt_valid, evt_code}, 9'h11C);
    chk("midrst_errs", {parity_err, frame_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
